data_path: RTL and testbench
============================

// Module: data_path
// PURPOSE
//  Minimal single-bus datapath for the tutorial CPU: three WIDTH-bit registers (A, B, Z),
//  a shared internal bus and two immediate adders. A control sequencer drives per-register
//  out/in strobes one micro-step per clock; the block has no control logic of its own.
//  Supports ldi A,imm / addi Z,A,imm / mv B,Z style micro-operations.
// PARAMETERS
//  WIDTH  8  data width of registers, bus, immediates and adders
// PORTS
//  clock               in   1      system clock; all registers capture on rising edge
//  clear               in   1      reset, asynchronous, active-low; clears A, B, Z to 0
//  AddImmediate        in   WIDTH  immediate added to bus value on Z load
//  RegisterAImmediate  in   WIDTH  immediate added to bus value on A load
//  RZout               in   1      drive Z onto bus
//  RAout               in   1      drive A onto bus
//  RBout               in   1      drive B onto bus
//  RAin                in   1      load A at next rising edge
//  RBin                in   1      load B at next rising edge
//  RZin                in   1      load Z at next rising edge
//  bus_q               out  WIDTH  current internal bus value (combinational, observation)
//  ra_q                out  WIDTH  register A contents
//  rb_q                out  WIDTH  register B contents
//  rz_q                out  WIDTH  register Z contents
// BEHAVIOUR
//  - Reset: clear=0 forces A=B=Z=0 immediately (no clock needed); held while clear=0.
//    Asserting clear mid-operation discards any pending load. Bus_q follows combinationally.
//  - Bus: combinational mux, priority RZout > RAout > RBout; no driver asserted -> bus = 0.
//    Exactly one out-strobe per step is expected; priority defines the multi-driver case.
//    No tri-states internally.
//  - Rising edge, clear=1, each register independently:
//      RAin: A <= (bus + RegisterAImmediate) mod 2^WIDTH
//      RBin: B <= bus
//      RZin: Z <= (bus + AddImmediate) mod 2^WIDTH
//    Strobe low -> register holds. Carry out of adders discarded.
//  - Bus value sampled before the edge: a register may be both source and destination in
//    one step (e.g. RAout+RAin with imm 1 increments A). Simultaneous loads of several
//    registers from the same bus value are legal.
//  - Latency: one clock from strobe assertion to updated ra_q/rb_q/rz_q; bus_q zero latency.
//  - Immediates only affect the adder results of A and Z; leave them 0 for plain moves.
//  - Controls change only away from the rising edge (sequencer drives them after the
//    falling edge); no synchronisers required.
// TESTING
//  1. clear=0 pulse with all strobes low -> ra_q=rb_q=rz_q=bus_q=0 before any clock edge.
//  2. ldi A,5: RegisterAImmediate=8'h05, RAin=1, no bus driver, one edge -> ra_q=8'h05.
//  3. addi: RAout=1, AddImmediate=8'h05, RZin=1, one edge -> bus_q=8'h05 during step,
//     rz_q=8'h0A; then mv: RZout=1, RBin=1 -> rb_q=8'h0A, ra_q still 8'h05.
//  4. Wrap: A=8'hFF, RAout=1, AddImmediate=8'h01, RZin=1 -> rz_q=8'h00.
//  5. Priority/self-load: RZout=RAout=1, RBin=1 -> rb_q=Z;
//     RAout=1, RAin=1, RegisterAImmediate=1 -> A increments by 1.
//  6. clear=0 asserted mid-step with RZin=1, between edges -> Z=0 immediately,
//     stays 0 at the edge while clear=0; loads resume after release.

Source files
------------

// File: rtl/data_path.sv
// Single-bus tutorial datapath: registers A, B, Z,
// a shared internal bus and two immediate adders.
module data_path #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] AddImmediate,
  input  logic [WIDTH-1:0] RegisterAImmediate,
  input  logic             RZout,
  input  logic             RAout,
  input  logic             RBout,
  input  logic             RAin,
  input  logic             RBin,
  input  logic             RZin,
  output logic [WIDTH-1:0] bus_q,
  output logic [WIDTH-1:0] ra_q,
  output logic [WIDTH-1:0] rb_q,
  output logic [WIDTH-1:0] rz_q
);

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rz;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] a_sum;
  logic [WIDTH-1:0] z_sum;

  // Bus mux: Z wins over A, A over B, idle bus reads zero
  always_comb begin
    bus = '0;
    if (RZout)
      bus = rz;
    else if (RAout)
      bus = ra;
    else if (RBout)
      bus = rb;
  end

  // Immediate adders; carry out is dropped
  always_comb begin
    a_sum = bus + RegisterAImmediate;
    z_sum = bus + AddImmediate;
  end

  // Register file: each register loads independently from the pre-edge bus
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ra <= '0;
      rb <= '0;
      rz <= '0;
    end else begin
      if (RAin)
        ra <= a_sum;
      if (RBin)
        rb <= bus;
      if (RZin)
        rz <= z_sum;
    end
  end

  assign bus_q = bus;
  assign ra_q  = ra;
  assign rb_q  = rb;
  assign rz_q  = rz;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: micro-op sequences
// with hand-computed register and bus values.
module tb_data_path;

  localparam int WIDTH = 8;

  logic             clock;
  logic             clear;
  logic [WIDTH-1:0] AddImmediate;
  logic [WIDTH-1:0] RegisterAImmediate;
  logic             RZout;
  logic             RAout;
  logic             RBout;
  logic             RAin;
  logic             RBin;
  logic             RZin;
  logic [WIDTH-1:0] bus_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] rz_q;

  int vecs = 0;
  int errs = 0;

  data_path #(.WIDTH(WIDTH)) dut (
    .clock              (clock),
    .clear              (clear),
    .AddImmediate       (AddImmediate),
    .RegisterAImmediate (RegisterAImmediate),
    .RZout              (RZout),
    .RAout              (RAout),
    .RBout              (RBout),
    .RAin               (RAin),
    .RBin               (RBin),
    .RZin               (RZin),
    .bus_q              (bus_q),
    .ra_q               (ra_q),
    .rb_q               (rb_q),
    .rz_q               (rz_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RZout = 0; RAout = 0; RBout = 0;
    RAin  = 0; RBin  = 0; RZin  = 0;
    AddImmediate = '0;
    RegisterAImmediate = '0;
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic next_step();
    @(negedge clock);
    idle();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    clear = 1'b1;

    // reset before any clock edge
    #2 clear = 1'b0;
    #1;
    check("rst_ra", ra_q, 8'h00);
    check("rst_rb", rb_q, 8'h00);
    check("rst_rz", rz_q, 8'h00);
    check("rst_bus", bus_q, 8'h00);
    @(negedge clock);
    clear = 1'b1;

    // ldi A,5
    next_step();
    RegisterAImmediate = 8'h05; RAin = 1;
    #1 check("ldi_bus", bus_q, 8'h00);
    edge_step();
    check("ldi_ra", ra_q, 8'h05);
    check("ldi_rz_hold", rz_q, 8'h00);

    // addi Z,A,5
    next_step();
    RAout = 1; AddImmediate = 8'h05; RZin = 1;
    #1 check("addi_bus", bus_q, 8'h05);
    edge_step();
    check("addi_rz", rz_q, 8'h0A);

    // mv B,Z
    next_step();
    RZout = 1; RBin = 1;
    #1 check("mv_bus", bus_q, 8'h0A);
    edge_step();
    check("mv_rb", rb_q, 8'h0A);
    check("mv_ra_hold", ra_q, 8'h05);

    // ldi A,FF then addi Z,A,1 wraps
    next_step();
    RegisterAImmediate = 8'hFF; RAin = 1;
    edge_step();
    check("ldiff_ra", ra_q, 8'hFF);
    next_step();
    RAout = 1; AddImmediate = 8'h01; RZin = 1;
    edge_step();
    check("wrap_rz", rz_q, 8'h00);
    check("wrap_ra_hold", ra_q, 8'hFF);

    // Z = A + 3 = 02
    next_step();
    RAout = 1; AddImmediate = 8'h03; RZin = 1;
    edge_step();
    check("z02_rz", rz_q, 8'h02);

    // bus priority
    next_step();
    RAout = 1; RBout = 1;
    #1 check("prio_ab_bus", bus_q, 8'hFF);
    RBout = 0; RZout = 1; RBin = 1;
    #1 check("prio_za_bus", bus_q, 8'h02);
    edge_step();
    check("prio_rb", rb_q, 8'h02);

    // self-load increment with wrap, then again
    next_step();
    RAout = 1; RAin = 1; RegisterAImmediate = 8'h01;
    edge_step();
    check("inc1_ra", ra_q, 8'h00);
    next_step();
    RAout = 1; RAin = 1; RegisterAImmediate = 8'h01;
    edge_step();
    check("inc2_ra", ra_q, 8'h01);

    // fan-out: B onto bus, A and Z load with distinct immediates
    next_step();
    RBout = 1; RAin = 1; RZin = 1;
    RegisterAImmediate = 8'h10; AddImmediate = 8'h20;
    #1 check("fan_bus", bus_q, 8'h02);
    edge_step();
    check("fan_ra", ra_q, 8'h12);
    check("fan_rz", rz_q, 8'h22);
    check("fan_rb_hold", rb_q, 8'h02);

    // clear mid-step with a pending Z load
    next_step();
    RAout = 1; AddImmediate = 8'h01; RZin = 1;
    #1 check("pend_bus", bus_q, 8'h12);
    #1 clear = 1'b0;
    #1;
    check("clr_rz", rz_q, 8'h00);
    check("clr_ra", ra_q, 8'h00);
    check("clr_rb", rb_q, 8'h00);
    check("clr_bus", bus_q, 8'h00);
    edge_step();
    check("clr_edge_rz", rz_q, 8'h00);

    // release and resume loads
    next_step();
    clear = 1'b1;
    AddImmediate = 8'h07; RZin = 1;
    edge_step();
    check("resume_rz", rz_q, 8'h07);
    check("resume_ra", ra_q, 8'h00);

    next_step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
